mul64_unit: RTL and testbench

Iterative 32x32 multiplier that serves the multicycle controller's multiply path. The controller's decoder selects MUL, UMULL or SMULL (ALUControl 100/101/110) and raises Start. This unit then runs a shift-add sequence and returns the product as one or two write-back beats (RdLo, then RdHi) with N/Z flags. It sits beside the ALU in the datapath and uses a Start/Busy/WbValid handshake with the controller FSM.

---
 rtl/mul64_unit_if.sv | 24 ++
 rtl/mul64_unit.sv | 146 ++++++++++++++
 tb/tb_mul64_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mul64_unit_if.sv
// Start/Busy/WbValid handshake bundle between the controller FSM and mul64_unit.
// Master is the controller (drives the request); slave is the multiplier (drives write-back).
// Carries no flow control of its own: Busy tells the master when Start will be sampled.
interface mul64_unit_if;
  logic        Start;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic        WbValid;
  logic        WbHalf;
  logic [31:0] WbData;
  logic [1:0]  MulFlags;

  modport master (
    output Start, ALUControl, SrcA, SrcB,
    input  Busy, WbValid, WbHalf, WbData, MulFlags
  );

  modport slave (
    input  Start, ALUControl, SrcA, SrcB,
    output Busy, WbValid, WbHalf, WbData, MulFlags
  );
endinterface

// File: rtl/mul64_unit.sv
// Iterative 32x32 shift-add multiplier (MUL / UMULL / SMULL) with one or two write-back beats.
// Latency: 33 cycles Start to first beat; with MUL_EARLY_TERM_EN defined, 2..33 cycles.
// Backpressure: none; Start is only sampled in IDLE, Start while Busy is dropped (no queueing).
module mul64_unit (
  input  logic         clk,
  input  logic         reset,
  mul64_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WBLO, S_WBHI} state_t;

  state_t      state_q, state_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;       // ALUControl[1:0]: 00 MUL, 01 UMULL, 10 SMULL
  logic        neg_q, neg_d;
  logic [31:0] wbdata_q, wbdata_d;
  logic [1:0]  flags_q, flags_d;

  logic        op_ok, accept, is_smull, is_long, run_done;
  logic [31:0] a_lat, b_lat;
  logic [63:0] sum, res_fix;
  logic        res_n, res_z;

  // Request decode, operand magnitudes and the per-iteration add / sign fix-up.
  always_comb begin
    op_ok    = bus.Start && (bus.ALUControl == 3'b100 || bus.ALUControl == 3'b101 ||
                             bus.ALUControl == 3'b110);
    accept   = (state_q == S_IDLE) && op_ok;
    is_smull = (bus.ALUControl == 3'b110);
    // |0x80000000| wraps back to 0x80000000, which is correct as an unsigned magnitude.
    a_lat    = (is_smull && bus.SrcA[31]) ? (~bus.SrcA + 32'd1) : bus.SrcA;
    b_lat    = (is_smull && bus.SrcB[31]) ? (~bus.SrcB + 32'd1) : bus.SrcB;
    is_long  = (op_q != 2'b00);
    sum      = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    res_fix  = neg_q ? (~sum + 64'd1) : sum;
`ifdef MUL_EARLY_TERM_EN
    // Stop once no set multiplier bits remain after this cycle's shift.
    run_done = (mplier_q[31:1] == 31'd0);
`else
    run_done = (cnt_q == 6'd31);
`endif
    res_n    = is_long ? res_fix[63] : res_fix[31];
    res_z    = is_long ? (res_fix == 64'd0) : (res_fix[31:0] == 32'd0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)   state_d = S_RUN;
      S_RUN:   if (run_done) state_d = S_WBLO;
      S_WBLO:  state_d = is_long ? S_WBHI : S_IDLE;
      S_WBHI:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs follow the state; data and flags come straight from registers.
  always_comb begin
    bus.Busy     = (state_q != S_IDLE);
    bus.WbValid  = (state_q == S_WBLO) || (state_q == S_WBHI);
    bus.WbHalf   = (state_q == S_WBHI);
    bus.WbData   = wbdata_q;
    bus.MulFlags = flags_q;
  end

  // Datapath next-state: latch on accept, shift-add in RUN, stage beat data in WB states.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    wbdata_d = wbdata_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mcand_d  = {32'd0, a_lat};
          mplier_d = b_lat;
          acc_d    = 64'd0;
          cnt_d    = 6'd0;
          op_d     = bus.ALUControl[1:0];
          neg_d    = is_smull && (bus.SrcA[31] ^ bus.SrcB[31]);
        end
      end
      S_RUN: begin
        acc_d    = run_done ? res_fix : sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        if (run_done) begin
          wbdata_d = res_fix[31:0];
          flags_d  = {res_n, res_z};
        end
      end
      S_WBLO: begin
        if (is_long) begin
          wbdata_d = acc_q[63:32];
        end else begin
          wbdata_d = 32'd0;
          flags_d  = 2'b00;
        end
      end
      S_WBHI: begin
        wbdata_d = 32'd0;
        flags_d  = 2'b00;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 6'd0;
      op_q     <= 2'b00;
      neg_q    <= 1'b0;
      wbdata_q <= 32'd0;
      flags_q  <= 2'b00;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      wbdata_q <= wbdata_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_mul64_unit.sv
// Self-checking bench for mul64_unit: directed vector table plus busy/reset/illegal-op sequences.
// Expected latency tracks the MUL_EARLY_TERM_EN build.
// Outputs are sampled 1 time unit after each rising edge.
module tb_mul64_unit;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [1:0]  flags;
  } vec_t;

`ifdef MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mul64_unit_if bus();

  mul64_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
    logic [31:0] m;
    int idx;
    m   = (op == 3'b110 && b[31]) ? (~b + 32'd1) : b;
    idx = 0;
    for (int i = 0; i < 32; i++) if (m[i]) idx = i;
    return EARLY ? idx + 2 : 33;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int lat;
    string tag;
    tag = $sformatf("v%0d", n);
    bus.Start      = 1'b1;
    bus.ALUControl = v.op;
    bus.SrcA       = v.a;
    bus.SrcB       = v.b;
    tick();
    bus.Start = 1'b0;
    check({tag, "_busy"}, 64'(bus.Busy), 64'd1);
    lat = 1;
    while (!bus.WbValid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat(v.op, v.b)));
    check({tag, "_lo_half"}, 64'(bus.WbHalf), 64'd0);
    check({tag, "_lo_data"}, 64'(bus.WbData), 64'(v.lo));
    check({tag, "_lo_flags"}, 64'(bus.MulFlags), 64'(v.flags));
    tick();
    if (v.op != 3'b100) begin
      check({tag, "_hi_valid"}, 64'(bus.WbValid), 64'd1);
      check({tag, "_hi_half"}, 64'(bus.WbHalf), 64'd1);
      check({tag, "_hi_data"}, 64'(bus.WbData), 64'(v.hi));
      check({tag, "_hi_flags"}, 64'(bus.MulFlags), 64'(v.flags));
      tick();
    end
    check({tag, "_end_valid"}, 64'(bus.WbValid), 64'd0);
    check({tag, "_end_busy"}, 64'(bus.Busy), 64'd0);
    check({tag, "_end_data"}, 64'(bus.WbData), 64'd0);
    check({tag, "_end_flags"}, 64'(bus.MulFlags), 64'd0);
  endtask

  initial begin
    vec_t vecs[9];
    int   beats;
    int   busy_cyc;
    logic [31:0] first_lo;

    checks   = 0;
    failures = 0;

    vecs[0] = '{3'b100, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 32'h0,         2'b00};
    vecs[1] = '{3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 2'b10};
    vecs[2] = '{3'b110, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'b10};
    vecs[3] = '{3'b110, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 2'b00};
    vecs[4] = '{3'b101, 32'h1234_5678, 32'h0000_0003, 32'h369D_0368, 32'h0000_0000, 2'b00};
    vecs[5] = '{3'b101, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'b01};
    vecs[6] = '{3'b100, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0,         2'b01};
    vecs[7] = '{3'b110, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 2'b10};
    vecs[8] = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0,         2'b10};

    // Reset state
    reset          = 1'b1;
    bus.Start      = 1'b0;
    bus.ALUControl = 3'b000;
    bus.SrcA       = 32'd0;
    bus.SrcB       = 32'd0;
    tick();
    tick();
    check("rst_busy",  64'(bus.Busy),     64'd0);
    check("rst_valid", 64'(bus.WbValid),  64'd0);
    check("rst_half",  64'(bus.WbHalf),   64'd0);
    check("rst_data",  64'(bus.WbData),   64'd0);
    check("rst_flags", 64'(bus.MulFlags), 64'd0);
    reset = 1'b0;
    tick();

    // Vector table, issued back-to-back
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Start pulses during a UMULL run are dropped
    bus.Start      = 1'b1;
    bus.ALUControl = 3'b101;
    bus.SrcA       = 32'hFFFF_FFFF;
    bus.SrcB       = 32'hFFFF_FFFF;
    tick();
    bus.ALUControl = 3'b100;
    bus.SrcA       = 32'd7;
    bus.SrcB       = 32'd6;
    beats    = 0;
    busy_cyc = 0;
    first_lo = 32'd0;
    for (int c = 1; c <= 60; c++) begin
      if (bus.Busy) busy_cyc++;
      if (bus.WbValid) begin
        if (beats == 0) first_lo = bus.WbData;
        beats++;
      end
      bus.Start = (c == 5 || c == 20);
      tick();
    end
    check("busy_ign_beats",   64'(beats),    64'd2);
    check("busy_ign_cycles",  64'(busy_cyc), 64'(exp_lat(3'b101, 32'hFFFF_FFFF) + 1));
    check("busy_ign_lo_data", 64'(first_lo), 64'd1);
    check("busy_ign_idle",    64'(bus.Busy), 64'd0);

    // Reset at RUN count 10 aborts; illegal op 011 afterwards is ignored
    bus.Start      = 1'b1;
    bus.ALUControl = 3'b101;
    bus.SrcA       = 32'hFFFF_FFFF;
    bus.SrcB       = 32'hFFFF_FFFF;
    tick();
    bus.Start = 1'b0;
    for (int c = 1; c < 11; c++) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_busy",  64'(bus.Busy),     64'd0);
    check("mid_rst_valid", 64'(bus.WbValid),  64'd0);
    check("mid_rst_data",  64'(bus.WbData),   64'd0);
    check("mid_rst_flags", 64'(bus.MulFlags), 64'd0);
    reset          = 1'b0;
    bus.Start      = 1'b1;
    bus.ALUControl = 3'b011;
    beats    = 0;
    busy_cyc = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      bus.Start = 1'b0;
      if (bus.WbValid) beats++;
      if (bus.Busy) busy_cyc++;
    end
    check("post_rst_beats",   64'(beats),    64'd0);
    check("illegal_op_busy",  64'(busy_cyc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
